// File: rtl/ipcu_arbiter.sv
// ipcu_arbiter: round-robin arbiter granting one IPCU at a time.
//   Purpose : latches one-cycle request pulses and hands a level grant to one
//             requester until that requester signals completion.
//   Latency : a strobe sampled at edge k (IDLE, pipe_en=1) gives arb_ack high
//             after edge k+1. Each grant ends with one RELEASE cycle.
//   Backpr. : pipe_en low holds requests pending and blocks new grants. It
//             never revokes a grant that is already in progress.
// Ports:
//   clk         - single clock, rising edge
//   rst         - asynchronous reset, active low
//   pipe_en     - global enable for new grants
//   rqs_strobe  - per-port request pulse
//   crt_in      - per-port completion pulse (only the granted port counts)
//   arb_ack     - one-hot level grant, high for the whole BUSY state
//   grant_id    - index of the current or last granted port
//   busy        - OR of arb_ack
//   timeout_err - one-cycle pulse when the watchdog revokes a grant
// Optional feature: define IPCU_ARB_TIMEOUT_EN to enable the BUSY watchdog.
//   The watchdog uses TIMEOUT_CYC. Without the macro, timeout_err is tied to 0.
module ipcu_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_en,
  input  logic [NUM_PORTS-1:0]         rqs_strobe,
  input  logic [NUM_PORTS-1:0]         crt_in,
  output logic [NUM_PORTS-1:0]         arb_ack,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int GW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] pend_q, pend_d;
  logic [GW-1:0]        gid_q, gid_d;
  logic [GW-1:0]        sel;
  logic                 sel_vld;
  logic                 grant_go;
  logic [NUM_PORTS-1:0] grant_mask;
  logic                 crt_ok;

  // Round-robin search: the scan starts one past the last grant. It wraps
  // around, so the last granted port is checked last.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx  = (int'(gid_q) + i) % NUM_PORTS;
      cand = GW'(idx);
      if (!sel_vld && pend_q[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  assign grant_go = (state_q == ST_IDLE) && pipe_en && sel_vld;
  assign crt_ok   = crt_in[gid_q];

  always_comb begin
    grant_mask = '0;
    if (grant_go) grant_mask[sel] = 1'b1;
  end

  // A new strobe on the port being granted takes priority over the clear.
  // The pending bit therefore survives that grant.
  assign pend_d = (pend_q & ~grant_mask) | rqs_strobe;
  assign gid_d  = grant_go ? sel : gid_q;

`ifdef IPCU_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wdog_q;
  logic          timeout_hit;
  logic          terr_q;
`endif

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
`ifdef IPCU_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      ST_IDLE:    if (grant_go) state_d = ST_BUSY;
      ST_BUSY: begin
        if (crt_ok) begin
          state_d = ST_RELEASE;
        end
`ifdef IPCU_ARB_TIMEOUT_EN
        // The counter holds the number of BUSY cycles already completed.
        // The last allowed cycle is the one where it reads TIMEOUT_CYC-1.
        else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
          state_d     = ST_RELEASE;
          timeout_hit = 1'b1;
        end
`endif
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      gid_q   <= GW'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gid_q   <= gid_d;
    end
  end

`ifdef IPCU_ARB_TIMEOUT_EN
  // The counter is held at zero outside BUSY. Each BUSY stay therefore
  // starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wdog_q <= (state_q == ST_BUSY) ? wdog_q + 1'b1 : '0;
      terr_q <= timeout_hit;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  // FSM outputs. The grant is decoded from state, so reset drops it
  // immediately.
  always_comb begin
    arb_ack = '0;
    if (state_q == ST_BUSY) arb_ack[gid_q] = 1'b1;
  end

  assign grant_id = gid_q;
  assign busy     = |arb_ack;

endmodule

// File: tb/tb_ipcu_arbiter.sv
// Bench for ipcu_arbiter (NUM_PORTS=4, TIMEOUT_CYC=8).
// The first part is a vector table with one row per clock edge.
// Hand-written sequences follow for pipe_en, long BUSY and async reset.
module tb_ipcu_arbiter;

  logic       clk;
  logic       rst;
  logic       pipe_en;
  logic [3:0] rqs_strobe;
  logic [3:0] crt_in;
  logic [3:0] arb_ack;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int nvec  = 0;
  int nfail = 0;

  ipcu_arbiter #(.NUM_PORTS(4), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_en     (pipe_en),
    .rqs_strobe  (rqs_strobe),
    .crt_in      (crt_in),
    .arb_ack     (arb_ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       pe;
    logic [3:0] stb;
    logic [3:0] crt;
    logic [3:0] ack;
    logic [1:0] gid;
    logic       bsy;
  } vec_t;

  vec_t tbl[26];

  // Inputs are driven at the falling edge. Outputs are read 1 time unit
  // after the next rising edge.
  task automatic step(input logic r, input logic pe, input logic [3:0] stb, input logic [3:0] crt);
    @(negedge clk);
    rst        = r;
    pipe_en    = pe;
    rqs_strobe = stb;
    crt_in     = crt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] e_ack, input logic [1:0] e_gid,
                     input logic e_bsy, input logic e_terr);
    nvec++;
    if (arb_ack !== e_ack || grant_id !== e_gid || busy !== e_bsy || timeout_err !== e_terr) begin
      nfail++;
      $display("FAIL %s: got ack=%b gid=%0d busy=%b terr=%b, want ack=%b gid=%0d busy=%b terr=%b",
               name, arb_ack, grant_id, busy, timeout_err, e_ack, e_gid, e_bsy, e_terr);
    end
  endtask

  initial begin
    rst        = 1'b0;
    pipe_en    = 1'b1;
    rqs_strobe = '0;
    crt_in     = '0;

    //            rst   pe    stb      crt      ack      gid   busy
    tbl[0]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0}; // reset state
    tbl[1]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 2'd3, 1'b0}; // strobe port 2
    tbl[3]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1}; // grant one edge later
    tbl[4]  = '{1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0100, 2'd2, 1'b1}; // crt on other port ignored
    tbl[5]  = '{1'b1, 1'b1, 4'b1011, 4'b0000, 4'b0100, 2'd2, 1'b1}; // ports 0,1,3 request
    tbl[6]  = '{1'b1, 1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0}; // RELEASE
    tbl[7]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0}; // IDLE
    tbl[8]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b1}; // RR: port 3 first
    tbl[9]  = '{1'b1, 1'b1, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1}; // wrap to port 0
    tbl[12] = '{1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1}; // then port 1
    tbl[15] = '{1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 4'b0000, 4'b1111, 4'b0000, 2'd1, 1'b0}; // crt outside BUSY ignored
    tbl[18] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b0}; // strobe port 0
    tbl[19] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1}; // grant + restrobe same edge
    tbl[20] = '{1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1}; // set won: granted again
    tbl[23] = '{1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0};
    tbl[24] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[25] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}; // nothing left pending

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rst_n, tbl[i].pe, tbl[i].stb, tbl[i].crt);
      chk($sformatf("vec%0d", i), tbl[i].ack, tbl[i].gid, tbl[i].bsy, 1'b0);
    end

    // pipe_en low blocks the grant; raising it grants on the next edge
    step(1'b1, 1'b0, 4'b0001, 4'b0000);
    chk("pe_low_strobe", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 4'b0000, 4'b0000);
      chk($sformatf("pe_low_hold%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("pe_high_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    // pipe_en dropping during BUSY keeps the grant
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'b0000, 4'b0000);
      chk($sformatf("pe_drop_busy%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 4'b0000, 4'b0001);
    chk("pe_drop_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("back_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Long BUSY with no completion
    step(1'b1, 1'b1, 4'b0100, 4'b0000);
    chk("hold_strobe", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("hold_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
`ifdef IPCU_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 4'b0000, 4'b0000);
      chk($sformatf("wdog_busy%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("wdog_revoke", 4'b0000, 2'd2, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("wdog_pulse_end", 4'b0000, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0100, 4'b0000);
    chk("wdog_restrobe", 4'b0000, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("wdog_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 4'b0000, 4'b0000);
      chk($sformatf("hold_busy%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
`endif

    // Async reset mid-BUSY with ports 1 and 3 pending
    step(1'b1, 1'b1, 4'b1010, 4'b0000);
    chk("rst_pend_set", 4'b0100, 2'd2, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_drop", 4'b0000, 2'd3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    chk("rst_held", 4'b0000, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 4'b0000, 4'b0000);
      chk($sformatf("rst_no_grant%0d", i), 4'b0000, 2'd3, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
